// File: rtl/serial_slave_port.sv
// serial_slave_port
// Slave-side endpoint of the bit-serial bus. It decodes the serial control
// frame (start bit, rw bit, address MSB first), deserialises write bursts
// into a local word memory, and serialises read bursts back on rD. During
// reads, ready marks the valid rD bits. All outputs are registered.
// The address shift below assumes ADDR_WIDTH >= 2 and DATA_WIDTH >= 2.

module serial_slave_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int CNT_MAX = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter value on the final address bit of a control frame (bit 0 is rw).
  localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(ADDR_WIDTH);
  // Counter value on the final bit of a data word.
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    WRITE,
    FETCH,
    SEND
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   shift;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    rw;

  // Word storage; deliberately not reset so contents survive rstN.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Assemble the completed write word and decide whether this edge stores it.
  always_comb begin
    wr_word = {shift[DATA_WIDTH-2:0], wD};
    mem_we  = (state == WRITE) && valid && (bit_cnt == WORD_LAST);
    rd_word = mem[addr];
  end

  // Memory write port: the word lands at the edge sampling its final valid bit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= wr_word;
    end
  end

  // Protocol FSM with registered ready/rD, address, shift register and counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      addr    <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      rw      <= 1'b0;
      ready   <= 1'b1;
      rD      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready   <= 1'b1;
          rD      <= 1'b0;
          bit_cnt <= '0;
          shift   <= '0;
          if (control) begin
            state <= CTRL;
          end
        end

        CTRL: begin
          ready <= 1'b1;
          rD    <= 1'b0;
          if (bit_cnt == '0) begin
            rw <= control;
          end else begin
            addr <= {addr[ADDR_WIDTH-2:0], control};
          end
          if (bit_cnt == CTRL_LAST) begin
            bit_cnt <= '0;
            if (rw) begin
              state <= WRITE;
            end else begin
              state <= FETCH;
              ready <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        WRITE: begin
          ready <= 1'b1;
          rD    <= 1'b0;
          if (valid && (bit_cnt == WORD_LAST)) begin
            // Word completes: memory is written by the write port this edge.
            bit_cnt <= '0;
            shift   <= '0;
            addr    <= addr + 1'b1;
            if (last) begin
              state <= IDLE;
            end
          end else if (last) begin
            // Ending mid-word drops the partial word without touching memory.
            bit_cnt <= '0;
            shift   <= '0;
            state   <= IDLE;
          end else if (valid) begin
            shift   <= wr_word;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        FETCH: begin
          bit_cnt <= '0;
          if (last) begin
            state <= IDLE;
            ready <= 1'b1;
            rD    <= 1'b0;
          end else begin
            // MSB goes straight to rD; the rest waits in the shift register.
            rD    <= rd_word[DATA_WIDTH-1];
            shift <= {rd_word[DATA_WIDTH-2:0], 1'b0};
            ready <= 1'b1;
            state <= SEND;
          end
        end

        SEND: begin
          if (last) begin
            state   <= IDLE;
            ready   <= 1'b1;
            rD      <= 1'b0;
            bit_cnt <= '0;
          end else if (bit_cnt == WORD_LAST) begin
            // Word finished: one ready=0 gap while the next word is fetched.
            state   <= FETCH;
            ready   <= 1'b0;
            rD      <= 1'b0;
            bit_cnt <= '0;
            addr    <= addr + 1'b1;
          end else begin
            rD      <= shift[DATA_WIDTH-1];
            shift   <= {shift[DATA_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            ready   <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          rD      <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port
// Directed bench for serial_slave_port (DATA_WIDTH=8, ADDR_WIDTH=4).
// Inputs change on the falling edge; outputs are observed on the falling
// edge, i.e. half a cycle after the rising edge that updated them.

module tb_serial_slave_port;

  logic clk = 1'b0;
  logic rstN;
  logic control;
  logic wD;
  logic valid;
  logic last;
  logic rD;
  logic ready;

  int tests_run    = 0;
  int tests_failed = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  serial_slave_port #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk    (clk),
    .rstN   (rstN),
    .control(control),
    .wD     (wD),
    .valid  (valid),
    .last   (last),
    .rD     (rD),
    .ready  (ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a control frame: start bit, rw bit, then 4 address bits MSB first.
  task automatic applyStimulus(input logic rw, input logic [3:0] a);
    control = 1'b1;
    tick();
    control = rw;
    tick();
    for (int i = 3; i >= 0; i--) begin
      control = a[i];
      tick();
    end
    control = 1'b0;
  endtask

  // Shift one word in on wD, optionally with valid=0 gaps and last on bit 8.
  task automatic write_word(input logic [7:0] d, input bit end_burst, input bit gaps,
                            input string tag);
    bit rdy_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (gaps && (i == 2 || i == 5)) begin
        valid = 1'b0;
        wD    = ~d[7-i];
        repeat (2) begin
          if (ready !== 1'b1) rdy_ok = 1'b0;
          tick();
        end
      end
      valid = 1'b1;
      wD    = d[7-i];
      last  = end_burst && (i == 7);
      if (ready !== 1'b1) rdy_ok = 1'b0;
      tick();
    end
    valid = 1'b0;
    last  = 1'b0;
    wD    = 1'b0;
    checkOutput({tag, "_ready_during_write"}, 32'(rdy_ok), 32'd1);
  endtask

  // Expect the ready=0 fetch gap, then collect 8 bits from rD.
  task automatic read_word(input logic [7:0] exp, input bit end_burst, input string tag);
    logic [7:0] got;
    bit rdy_ok = 1'b1;
    checkOutput({tag, "_gap_ready"}, 32'(ready), 32'd0);
    checkOutput({tag, "_gap_rD"}, 32'(rD), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      got[7-i] = rD;
      if (ready !== 1'b1) rdy_ok = 1'b0;
      last = end_burst && (i == 7);
      tick();
    end
    last = 1'b0;
    checkOutput({tag, "_data"}, 32'(got), 32'(exp));
    checkOutput({tag, "_ready_during_send"}, 32'(rdy_ok), 32'd1);
    if (end_burst) begin
      checkOutput({tag, "_idle_ready"}, 32'(ready), 32'd1);
      checkOutput({tag, "_idle_rD"}, 32'(rD), 32'd0);
    end
  endtask

  // Directed sequence following the block's test plan.
  initial begin
    rstN    = 1'b0;
    control = 1'b0;
    wD      = 1'b0;
    valid   = 1'b0;
    last    = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_rD", 32'(rD), 32'd0);
    rstN = 1'b1;
    tick();
    checkOutput("idle_ready", 32'(ready), 32'd1);

    // Single write of 0xA5 to address 3, read back straight after.
    applyStimulus(1'b1, 4'd3);
    write_word(8'hA5, 1'b1, 1'b0, "wr3");
    applyStimulus(1'b0, 4'd3);
    read_word(8'hA5, 1'b1, "rd3");

    // Burst across the top address: 15 then wraps to 0.
    applyStimulus(1'b1, 4'd15);
    write_word(8'h11, 1'b0, 1'b0, "wr15");
    write_word(8'h22, 1'b1, 1'b0, "wr0");
    applyStimulus(1'b0, 4'd15);
    read_word(8'h11, 1'b0, "rd15");
    read_word(8'h22, 1'b1, "rd0_wrap");

    // Write with valid gaps must give the same word as a gapless write.
    applyStimulus(1'b1, 4'd5);
    write_word(8'h3C, 1'b1, 1'b1, "wr5_gaps");
    applyStimulus(1'b0, 4'd5);
    read_word(8'h3C, 1'b1, "rd5_gaps");

    // Partial word: five valid 1s, then last; address 5 must keep 0x3C.
    applyStimulus(1'b1, 4'd5);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      wD    = 1'b1;
      tick();
    end
    valid = 1'b0;
    wD    = 1'b0;
    last  = 1'b1;
    tick();
    last  = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_rD", 32'(rD), 32'd0);
    applyStimulus(1'b0, 4'd5);
    read_word(8'h3C, 1'b1, "rd5_after_abort");

    // Reset during SEND on bit 4 of 0x11 (that bit is 1).
    applyStimulus(1'b0, 4'd15);
    checkOutput("rst_gap_ready", 32'(ready), 32'd0);
    tick();
    repeat (3) tick();
    checkOutput("rst_bit4_before", 32'(rD), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_async_rD", 32'(rD), 32'd0);
    checkOutput("rst_async_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    applyStimulus(1'b0, 4'd15);
    read_word(8'h11, 1'b1, "rd15_after_rst");
    applyStimulus(1'b0, 4'd0);
    read_word(8'h22, 1'b1, "rd0_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
